// File: rtl/logic_result_stage.sv
// Registered two-entry output stage behind the 32-bit logic unit: buffers each
// result with its select code and precomputed status flags behind valid/ready handshakes.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic [1:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic             out_illegal,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready on the
  // same side; valid never waits on ready, and ready never looks at out_ready.

  // Entry layout: {result, sel, zero, neg, parity, illegal}
  localparam int EW = WIDTH + 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] head_q, tail_q, in_entry;
  logic          push, pop;
  logic          load_head_in, load_tail_in, load_head_tail, clear_head;

  assign in_entry  = {in_r, in_sel, (in_r == '0), in_r[WIDTH-1], ^in_r, (in_sel == 2'b11)};
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_tail_in   = 1'b0;
    load_head_tail = 1'b0;
    clear_head     = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        // With push and pop together the incoming entry replaces the departing head.
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_tail_in = 1'b1;
          state_nxt    = FULL;
        end else if (pop) begin
          clear_head = 1'b1;
          state_nxt  = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_tail = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      illegal_seen <= 1'b0;
      op_count     <= '0;
    end else begin
      if (load_head_in)        head_q <= in_entry;
      else if (load_head_tail) head_q <= tail_q;
      else if (clear_head)     head_q <= '0;
      if (load_tail_in)        tail_q <= in_entry;
      if (push && (in_sel == 2'b11)) illegal_seen <= 1'b1;
      if (pop) op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_r       = head_q[EW-1:6];
  assign out_sel     = head_q[5:4];
  assign out_zero    = head_q[3];
  assign out_neg     = head_q[2];
  assign out_parity  = head_q[1];
  assign out_illegal = head_q[0];

endmodule
